// File: rtl/cle_pkg.sv
// Shared types and constants for the sequence-unlock block and its LFSR.
package cle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEQ      = 2'd1,
    ST_UNLOCKED = 2'd2
  } state_t;

  // Taps for x^6 + x^5 + 1: feedback is q[5] ^ q[4]
  localparam logic [5:0] LFSR_TAPS  = 6'b110000;
  localparam logic [5:0] SEED_DEF   = 6'h2D;
  localparam logic [3:0] RELOCK_NIB = 4'hF;

endpackage

// File: rtl/cle_lfsr.sv
// 6-bit Fibonacci LFSR with synchronous load, step enable and a zero guard
// that reloads SEED should the register ever hold zero.
module cle_lfsr
  import cle_pkg::*;
#(
  parameter logic [5:0] SEED = SEED_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [5:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= SEED;
    end else if (load || (q == 6'd0)) begin
      q <= SEED;
    end else if (step) begin
      q <= {q[4:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/cle_seq_unlock.sv
// Bus-sniffing sequence unlock: a keyed series of read hits opens an LFSR
// response window. Optional relock timer is compiled in by CLE_RELOCK_TIMER_EN.
//
// state        | meaning
// ST_IDLE      | locked, no key progress (k = 0)
// ST_SEQ       | locked, k key steps matched so far
// ST_UNLOCKED  | key complete, reads return LFSR bits
module cle_seq_unlock
  import cle_pkg::*;
#(
  parameter int                   ADDR_W  = 14,
  parameter logic [1:0]           WIN_TAG = 2'b01,
  parameter int                   KEY_LEN = 4,
  parameter logic [KEY_LEN*4-1:0] KEY     = {4'h2, 4'h9, 4'hA, 4'hC},
  parameter int                   DOUT_W  = 2,
  parameter logic [5:0]           SEED    = SEED_DEF
`ifdef CLE_RELOCK_TIMER_EN
  , parameter logic [15:0]        TIMEOUT = 16'd50000
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel_n,
  input  logic              stb,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_oe,
  output logic              unlocked
);

  localparam logic [2:0] K_LAST = 3'(KEY_LEN - 1);

  state_t     state;
  logic [2:0] k;
  logic [5:0] lfsr;
  logic [5:0] k_ext;
  logic [3:0] nib;
  logic [3:0] key_arr [8];
  logic       hit;
  logic       rd_hit;
  logic       key_match;
  logic       lfsr_load;
  logic       lfsr_step;
  logic       relock_wr;
  logic       timeout;
  logic       unused_bits;

  assign hit       = !sel_n && stb && (addr[ADDR_W-1:ADDR_W-2] == WIN_TAG);
  assign rd_hit    = hit && rd;
  assign nib       = addr[7:4];
  assign key_match = (nib == key_arr[k]);
  assign k_ext     = {3'b000, k};

  assign lfsr_load = rd_hit && (state != ST_UNLOCKED) && key_match && (k == K_LAST);
  assign lfsr_step = rd_hit && (state == ST_UNLOCKED);
  assign relock_wr = hit && !rd && (state == ST_UNLOCKED) && (nib == RELOCK_NIB);

  assign unused_bits = ^{addr, k_ext, lfsr};

  // Key nibbles unpacked so step 0 (the MS nibble) sits at index 0
  always_comb begin
    for (int i = 0; i < 8; i++) key_arr[i] = 4'h0;
    for (int i = 0; i < KEY_LEN; i++) key_arr[i] = KEY[(KEY_LEN-1-i)*4 +: 4];
  end

`ifdef CLE_RELOCK_TIMER_EN
  logic [15:0] timer;

  assign timeout = (state == ST_UNLOCKED) && !hit && (timer == TIMEOUT - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= 16'd0;
    end else if (hit || (state != ST_UNLOCKED) || timeout) begin
      timer <= 16'd0;
    end else begin
      timer <= timer + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      k        <= 3'd0;
      unlocked <= 1'b0;
    end else if (rd_hit && (state != ST_UNLOCKED)) begin
      if (key_match) begin
        if (k == K_LAST) begin
          state    <= ST_UNLOCKED;
          k        <= 3'd0;
          unlocked <= 1'b1;
        end else begin
          state <= ST_SEQ;
          k     <= k + 3'd1;
        end
      end else if (state == ST_SEQ) begin
        // A wrong nibble may itself be the first key step
        if (nib == key_arr[0]) begin
          k <= 3'd1;
        end else begin
          state <= ST_IDLE;
          k     <= 3'd0;
        end
      end
    end else if (state == ST_UNLOCKED) begin
      if (relock_wr || timeout) begin
        state    <= ST_IDLE;
        k        <= 3'd0;
        unlocked <= 1'b0;
      end
    end
  end

  cle_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (lfsr)
  );

  assign dout_oe = rd_hit;

  always_comb begin
    dout = '0;
    if (dout_oe) begin
      dout = (state == ST_UNLOCKED) ? lfsr[DOUT_W-1:0] : k_ext[DOUT_W-1:0];
    end
  end

endmodule

// File: tb/tb_cle_seq_unlock.sv
// Directed bench for cle_seq_unlock with default parameters; the relock
// timer scenario runs only when CLE_RELOCK_TIMER_EN is defined.
module tb_cle_seq_unlock;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel_n;
  logic        stb;
  logic        rd;
  logic [13:0] addr;
  logic [1:0]  dout;
  logic        dout_oe;
  logic        unlocked;

  int checks = 0;
  int errors = 0;

  logic [1:0] s_dout;
  logic       s_oe;

  logic [3:0] key_seq  [4] = '{4'h2, 4'h9, 4'hA, 4'hC};
  logic [1:0] lfsr_exp [4] = '{2'b01, 2'b11, 2'b11, 2'b10};
  logic [3:0] rst_seq  [6] = '{4'h2, 4'h9, 4'h2, 4'h9, 4'hA, 4'hC};
  logic [1:0] rst_dec  [6] = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};

  always #5 clk = ~clk;

`ifdef CLE_RELOCK_TIMER_EN
  cle_seq_unlock #(.TIMEOUT(16'd10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel_n    (sel_n),
    .stb      (stb),
    .rd       (rd),
    .addr     (addr),
    .dout     (dout),
    .dout_oe  (dout_oe),
    .unlocked (unlocked)
  );
`else
  cle_seq_unlock dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel_n    (sel_n),
    .stb      (stb),
    .rd       (rd),
    .addr     (addr),
    .dout     (dout),
    .dout_oe  (dout_oe),
    .unlocked (unlocked)
  );
`endif

  function automatic logic [13:0] mk(input logic [1:0] tag, input logic [3:0] n);
    return {tag, 4'h0, n, 4'h0};
  endfunction

  // One bus cycle starting just after a rising edge; outputs sampled mid-cycle
  task automatic cyc(input logic s_n, input logic r, input logic [13:0] a);
    sel_n = s_n; stb = 1'b1; rd = r; addr = a;
    @(negedge clk);
    s_dout = dout;
    s_oe   = dout_oe;
    @(posedge clk);
    #1;
    stb = 1'b0; sel_n = 1'b1; rd = 1'b0;
  endtask

  task automatic rdh(input logic [3:0] n);
    cyc(1'b0, 1'b1, mk(2'b01, n));
  endtask

  task automatic wrh(input logic [3:0] n);
    cyc(1'b0, 1'b0, mk(2'b01, n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_unlock();
    for (int i = 0; i < 4; i++) rdh(key_seq[i]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sel_n = 1'b1; stb = 1'b0; rd = 1'b0; addr = '0;
    #2;
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked got %b exp 0", unlocked); end
    checks++;
    if (dout_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", dout_oe); end
    sel_n = 1'b0; stb = 1'b1; rd = 1'b1; addr = mk(2'b01, 4'h2);
    #1;
    checks++;
    if (dout_oe !== 1'b1 || dout !== 2'b00) begin
      errors++; $display("FAIL reset_read oe=%b dout=%b exp oe=1 dout=00", dout_oe, dout);
    end
    @(posedge clk); #1;
    stb = 1'b0; sel_n = 1'b1; rd = 1'b0;
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_unlock();
    for (int i = 0; i < 4; i++) begin
      rdh(key_seq[i]);
      checks++;
      if (s_oe !== 1'b1 || s_dout !== 2'(i)) begin
        errors++; $display("FAIL unlock_decoy step %0d oe=%b dout=%b exp dout=%0d", i, s_oe, s_dout, i);
      end
      if (i == 2) begin
        checks++;
        if (unlocked !== 1'b0) begin errors++; $display("FAIL unlock_early got %b exp 0", unlocked); end
      end
    end
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL unlock_set got %b exp 1", unlocked); end
    for (int i = 0; i < 4; i++) begin
      rdh(4'h0);
      checks++;
      if (s_dout !== lfsr_exp[i]) begin
        errors++; $display("FAIL unlock_lfsr read %0d got %b exp %b", i, s_dout, lfsr_exp[i]);
      end
    end
  endtask

  task automatic test_restart();
    wrh(4'hF);
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL restart_relock got %b exp 0", unlocked); end
    for (int i = 0; i < 6; i++) begin
      rdh(rst_seq[i]);
      checks++;
      if (s_dout !== rst_dec[i]) begin
        errors++; $display("FAIL restart_decoy read %0d got %0d exp %0d", i, s_dout, rst_dec[i]);
      end
      if (i == 4) begin
        checks++;
        if (unlocked !== 1'b0) begin errors++; $display("FAIL restart_early got %b exp 0", unlocked); end
      end
    end
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL restart_unlock got %b exp 1", unlocked); end
  endtask

  task automatic test_miss();
    wrh(4'hF);
    cyc(1'b1, 1'b1, mk(2'b01, 4'h2));
    checks++;
    if (s_oe !== 1'b0 || s_dout !== 2'b00) begin
      errors++; $display("FAIL miss_sel oe=%b dout=%b exp 0 00", s_oe, s_dout);
    end
    cyc(1'b0, 1'b1, mk(2'b11, 4'h2));
    checks++;
    if (s_oe !== 1'b0 || s_dout !== 2'b00) begin
      errors++; $display("FAIL miss_tag oe=%b dout=%b exp 0 00", s_oe, s_dout);
    end
    wrh(4'h2);
    checks++;
    if (s_oe !== 1'b0) begin errors++; $display("FAIL miss_write_oe got %b exp 0", s_oe); end
    rdh(4'h2);
    checks++;
    if (s_dout !== 2'd0) begin errors++; $display("FAIL miss_k_held got %0d exp 0", s_dout); end
    rdh(4'h9);
    checks++;
    if (s_dout !== 2'd1) begin errors++; $display("FAIL miss_k1 got %0d exp 1", s_dout); end
    sel_n = 1'b0; rd = 1'b1; stb = 1'b0; addr = mk(2'b01, 4'hA);
    @(negedge clk);
    checks++;
    if (dout_oe !== 1'b0) begin errors++; $display("FAIL miss_nostb oe got %b exp 0", dout_oe); end
    @(posedge clk); #1;
    sel_n = 1'b1; rd = 1'b0;
    rdh(4'hA);
    checks++;
    if (s_dout !== 2'd2) begin errors++; $display("FAIL miss_k2 got %0d exp 2", s_dout); end
    rdh(4'h0);
    rdh(4'h2);
    checks++;
    if (s_dout !== 2'd0) begin errors++; $display("FAIL miss_to_idle got %0d exp 0", s_dout); end
    rdh(4'h0);
  endtask

  task automatic test_relock();
    do_unlock();
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL relock_unlock got %b exp 1", unlocked); end
    wrh(4'h2);
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL relock_ignore got %b exp 1", unlocked); end
    rdh(4'h0);
    checks++;
    if (s_dout !== 2'b01) begin errors++; $display("FAIL relock_nostep got %b exp 01", s_dout); end
    wrh(4'hF);
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL relock_clear got %b exp 0", unlocked); end
    rdh(4'h5);
    checks++;
    if (s_oe !== 1'b1 || s_dout !== 2'b00) begin
      errors++; $display("FAIL relock_decoy oe=%b dout=%b exp 1 00", s_oe, s_dout);
    end
  endtask

  task automatic test_reset_mid();
    do_unlock();
    rdh(4'h0);
    rdh(4'h0);
    sel_n = 1'b0; stb = 1'b1; rd = 1'b1; addr = mk(2'b01, 4'h0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL rstmid_unlocked got %b exp 0", unlocked); end
    checks++;
    if (dut.u_lfsr.q !== 6'h2D) begin errors++; $display("FAIL rstmid_lfsr got %h exp 2d", dut.u_lfsr.q); end
    checks++;
    if (dout_oe !== 1'b1 || dout !== 2'b00) begin
      errors++; $display("FAIL rstmid_out oe=%b dout=%b exp 1 00", dout_oe, dout);
    end
    @(posedge clk); #1;
    stb = 1'b0; sel_n = 1'b1; rd = 1'b0;
    rst_n = 1'b1;
    idle(1);
    do_unlock();
    rdh(4'h0);
    checks++;
    if (s_dout !== 2'b01) begin errors++; $display("FAIL rstmid_reseed got %b exp 01", s_dout); end
    wrh(4'hF);
  endtask

`ifdef CLE_RELOCK_TIMER_EN
  task automatic test_timer();
    do_unlock();
    idle(9);
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL timer_before got %b exp 1", unlocked); end
    idle(1);
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL timer_expire got %b exp 0", unlocked); end
    do_unlock();
    idle(8);
    rdh(4'h0);
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL timer_hit9 got %b exp 1", unlocked); end
    idle(9);
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL timer_rearm got %b exp 1", unlocked); end
    idle(1);
    checks++;
    if (unlocked !== 1'b0) begin errors++; $display("FAIL timer_rearm_expire got %b exp 0", unlocked); end
  endtask
`else
  task automatic test_persist();
    do_unlock();
    idle(40);
    checks++;
    if (unlocked !== 1'b1) begin errors++; $display("FAIL persist got %b exp 1", unlocked); end
    wrh(4'hF);
  endtask
`endif

  initial begin
    test_reset();
    test_unlock();
    test_restart();
    test_miss();
    test_relock();
    test_reset_mid();
`ifdef CLE_RELOCK_TIMER_EN
    test_timer();
`else
    test_persist();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cle_seq_unlock.md
CLE_SEQ_UNLOCK -- requirements
Module: cle_seq_unlock

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: bus address width.
REQ-002 SHALL have parameter WIN_TAG, default 2'b01: required value of addr[ADDR_W-1:ADDR_W-2], the decode window.
REQ-003 SHALL have parameter KEY_LEN, default 4: number of key steps, range 2..8.
REQ-004 SHALL have parameter KEY, a packed KEY_LEN x 4-bit vector, default {4'h2,4'h9,4'hA,4'hC}; step 0 is the most significant nibble.
REQ-005 SHALL have parameter DOUT_W, default 2: response width, range 1..6.
REQ-006 SHALL have parameter SEED, default 6'h2D: LFSR load value on unlock; must be nonzero.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port sel_n, input, 1 bit: active-low chip select.
REQ-010 SHALL have port stb, input, 1 bit: one-cycle bus-cycle strobe.
REQ-011 SHALL have port rd, input, 1 bit: 1 = read, 0 = write.
REQ-012 SHALL have port addr, input, ADDR_W bits: bus address.
REQ-013 SHALL have port dout, output, DOUT_W bits: response data.
REQ-014 SHALL have port dout_oe, output, 1 bit: output enable for the external tristate.
REQ-015 SHALL have port unlocked, output, 1 bit: level, 1 while in state UNLOCKED.

Function
REQ-016 SHALL define hit = !sel_n & stb & (addr[ADDR_W-1:ADDR_W-2]==WIN_TAG).
REQ-017 SHALL define nib = addr[7:4].
REQ-018 SHALL implement states IDLE, SEQ and UNLOCKED, with a step index k in 0..KEY_LEN-1.
REQ-019 In IDLE or SEQ, a read hit with nib==KEY[k] SHALL advance: if k==KEY_LEN-1, go to UNLOCKED and load LFSR with SEED; otherwise k+1 and state SEQ.
REQ-020 In SEQ, a read hit with nib!=KEY[k] SHALL restart: if nib==KEY[0], set k=1 in SEQ; otherwise k=0 in IDLE.
REQ-021 Non-hit cycles and write hits while locked SHALL hold all state.
REQ-022 In UNLOCKED, each read hit SHALL step the 6-bit Fibonacci LFSR (x^6+x^5+1) once.
REQ-023 A write hit in UNLOCKED with nib==4'hF SHALL go to IDLE with k=0; other writes SHALL be ignored.
REQ-024 dout_oe SHALL equal (hit & rd), combinationally in the same cycle.
REQ-025 dout SHALL be lfsr[DOUT_W-1:0] in UNLOCKED and k[DOUT_W-1:0] (decoy) otherwise, using the pre-edge value.
REQ-026 dout SHALL be all zeros when dout_oe=0.
REQ-027 unlocked SHALL be registered; it asserts on the edge that enters UNLOCKED.
REQ-028 The LFSR SHALL never hold zero; a zero value SHALL be forced to SEED on the next edge.

Reset
REQ-029 On rst_n low, the block SHALL immediately enter IDLE with k=0, lfsr=SEED, unlocked=0 and the timer cleared, regardless of any operation in progress.
REQ-030 During reset, dout_oe and dout SHALL still follow REQ-024 and REQ-025, using the reset state.

Configuration
REQ-031 Macro CLE_RELOCK_TIMER_EN SHALL compile in a relock timer, with parameter TIMEOUT, default 16'd50000.
REQ-032 With the macro defined, a 16-bit counter SHALL clear on every hit and count cycles in UNLOCKED; on reaching TIMEOUT the block SHALL return to IDLE with k=0.
REQ-033 Without the macro, UNLOCKED SHALL persist until a relock write (REQ-023) or reset, and no counter logic SHALL exist.

Structure
REQ-034 Package cle_pkg SHALL hold the state enum, LFSR tap constant, default SEED and relock nibble 4'hF.
REQ-035 Sub-module cle_lfsr (6-bit, with load, step and zero-guard) SHALL be instantiated once.

Verification
REQ-036 Reset, then read hits with nib 2,9,A,C and defaults -> unlocked=1 after the 4th edge; the 5th read shows dout=2'b01 (SEED[1:0]).
REQ-037 Reads with nib 2,9,2,9,A,C -> the third read restarts to k=1; unlocked=1 after the 6th read.
REQ-038 Read with sel_n=1 or addr[13:12]=2'b11 and nib=2 -> k unchanged, dout_oe=0.
REQ-039 Unlock, then write hit with nib=F -> unlocked=0 next edge; the following read shows decoy dout=0.
REQ-040 Unlock, then assert rst_n low mid-read -> unlocked=0 immediately, lfsr=6'h2D.
REQ-041 With CLE_RELOCK_TIMER_EN and TIMEOUT=10, unlock then idle for 10 cycles -> unlocked=0; a hit at cycle 9 keeps unlocked=1.
